// File: rtl/conv_pkg.sv
// Shared definitions for the 5x5 convolution timing controller: lock FSM
// encoding, default geometry widths and the filter datapath latency.
package conv_pkg;

   localparam int AW_DEF         = 12;
   localparam int LW_DEF         = 11;
   localparam int LOCK_LINES_DEF = 4;

   // Pixel-clock latency from rx_* to tx_* through the filter datapath; the
   // integrator delays bypass by this amount to keep it aligned with video.
   localparam int DP_DELAY = 27;

   typedef enum logic [1:0] {
      UNLOCK = 2'd0,
      TRACK  = 2'd1,
      LOCK   = 2'd2
   } lock_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Registered rising-edge detector: pulse is high for one cycle, one cycle
// after the input is first seen high.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic din_prev;

   // NOTE: non-blocking assignments let rise see the old din_prev value,
   // which is exactly what makes this an edge detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         din_prev <= 1'b0;
         rise     <= 1'b0;
      end else begin
         din_prev <= din;
         rise     <= din & ~din_prev;
      end
   end

endmodule

// File: rtl/conv_timing_ctrl.sv
// Line/frame timing measurement, line-buffer address generation and lock
// tracking for the convolution pipeline. Optional statistics: CONV_CTRL_STATS_EN.
module conv_timing_ctrl
   import conv_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int LOCK_LINES = LOCK_LINES_DEF,
   parameter int LW         = LW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_hs,
   input  logic          rx_vs,
   input  logic [7:0]    sw,
   output logic [AW-1:0] addr,
   output logic [AW-1:0] line_len,
   output logic [LW-1:0] frame_lines,
   output logic [7:0]    kern_sel,
   output logic          locked,
   output logic          bypass
`ifdef CONV_CTRL_STATS_EN
   ,
   output logic [15:0]   unlock_cnt,
   output logic [15:0]   frame_cnt
`endif
);

   localparam int             MW         = $clog2(LOCK_LINES + 1);
   localparam logic [AW-1:0]  WIDTH_MAX  = '1;
   // LOCK_LINES is expected to be at least 2: one candidate plus matches.
   localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCK_LINES - 2);

   logic          hs_edge;
   logic          vs_edge;
   logic [AW-1:0] width_cnt;
   logic [AW-1:0] cand;
   logic [MW-1:0] match_cnt;
   logic [LW-1:0] line_cnt;
   lock_state_t   state;
   logic          timeout;
   logic          width_match;
   logic          lock_drop;

   sync_edge_det u_hs_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (rx_hs),
      .rise (hs_edge)
   );

   sync_edge_det u_vs_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (rx_vs),
      .rise (vs_edge)
   );

   assign timeout     = (width_cnt == WIDTH_MAX);
   assign width_match = (width_cnt == cand);
   assign lock_drop   = (state == LOCK) && (timeout || (hs_edge && !width_match));

   // Line period measurement; the counter parks at its maximum when hs is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_cnt <= '0;
         line_len  <= '0;
      end else if (hs_edge) begin
         width_cnt <= '0;
         line_len  <= width_cnt;
      end else if (!timeout) begin
         width_cnt <= width_cnt + AW'(1);
      end
   end

   // Free-running line-buffer address; >= keeps it bounded when line_len shrinks.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
      end else if (addr >= line_len) begin
         addr <= '0;
      end else begin
         addr <= addr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_cnt    <= '0;
         frame_lines <= '0;
      end else if (vs_edge) begin
         frame_lines <= line_cnt;
         line_cnt    <= hs_edge ? LW'(1) : '0;
      end else if (hs_edge) begin
         line_cnt <= line_cnt + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= UNLOCK;
         cand      <= '0;
         match_cnt <= '0;
         locked    <= 1'b0;
         bypass    <= 1'b1;
         kern_sel  <= '0;
      end else begin
         if (timeout) begin
            state  <= UNLOCK;
            locked <= 1'b0;
         end else if (hs_edge) begin
            unique case (state)
               UNLOCK: begin
                  cand      <= width_cnt;
                  match_cnt <= '0;
                  state     <= TRACK;
               end
               TRACK: begin
                  if (width_match) begin
                     match_cnt <= match_cnt + MW'(1);
                     if (match_cnt == MATCH_LAST) begin
                        state  <= LOCK;
                        locked <= 1'b1;
                     end
                  end else begin
                     cand      <= width_cnt;
                     match_cnt <= '0;
                  end
               end
               LOCK: begin
                  if (!width_match) begin
                     state  <= UNLOCK;
                     locked <= 1'b0;
                  end
               end
               default: begin
                  state  <= UNLOCK;
                  locked <= 1'b0;
               end
            endcase
         end

         // Filtering resumes only at a frame boundary after lock is regained.
         if (lock_drop) begin
            bypass <= 1'b1;
         end else if (vs_edge && locked) begin
            bypass <= 1'b0;
         end

         if (vs_edge && locked) begin
            kern_sel <= sw;
         end
      end
   end

`ifdef CONV_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         unlock_cnt <= '0;
         frame_cnt  <= '0;
      end else begin
         if (lock_drop && (unlock_cnt != 16'hFFFF)) begin
            unlock_cnt <= unlock_cnt + 16'd1;
         end
         if (vs_edge && locked) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_conv_timing_ctrl.sv
// Directed bench for conv_timing_ctrl: stimulus schedules expected output
// values per clock cycle into a scoreboard that a monitor checks on negedge.
module tb_conv_timing_ctrl;

   localparam int AW = 12;
   localparam int LW = 11;

   typedef enum {S_ADDR, S_LINE_LEN, S_FRAME_LINES, S_KERN_SEL, S_LOCKED, S_BYPASS} sig_e;

   typedef struct {
      int   cyc;
      sig_e sig;
      int   val;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_hs;
   logic          rx_vs;
   logic [7:0]    sw;
   logic [AW-1:0] addr;
   logic [AW-1:0] line_len;
   logic [LW-1:0] frame_lines;
   logic [7:0]    kern_sel;
   logic          locked;
   logic          bypass;
`ifdef CONV_CTRL_STATS_EN
   logic [15:0]   unlock_cnt;
   logic [15:0]   frame_cnt;
`endif

   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   conv_timing_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rx_hs       (rx_hs),
      .rx_vs       (rx_vs),
      .sw          (sw),
      .addr        (addr),
      .line_len    (line_len),
      .frame_lines (frame_lines),
      .kern_sel    (kern_sel),
      .locked      (locked),
      .bypass      (bypass)
`ifdef CONV_CTRL_STATS_EN
      ,
      .unlock_cnt  (unlock_cnt),
      .frame_cnt   (frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(sig_e s);
      case (s)
         S_ADDR:        return 32'(addr);
         S_LINE_LEN:    return 32'(line_len);
         S_FRAME_LINES: return 32'(frame_lines);
         S_KERN_SEL:    return 32'(kern_sel);
         S_LOCKED:      return 32'(locked);
         default:       return 32'(bypass);
      endcase
   endfunction

   task automatic check(string nm, int c, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, c, act, expv);
      end
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].sig.name(), cyc, actual(sb[i].sig), 32'(sb[i].val));
            sb.delete(i);
         end
      end
   end

   task automatic exp_at(int c, sig_e s, int v);
      exp_t e;
      e.cyc = c;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_reset(int c);
      exp_at(c, S_ADDR, 0);
      exp_at(c, S_LINE_LEN, 0);
      exp_at(c, S_FRAME_LINES, 0);
      exp_at(c, S_KERN_SEL, 0);
      exp_at(c, S_LOCKED, 0);
      exp_at(c, S_BYPASS, 1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One line starting now: hs is seen at the next edge, so hs_edge effects
   // land 2 cycles after the call; a vs at offset k lands at k+2.
   task automatic drive_line(int p, int hs_hi, int vs_off, int sw_off = -1,
                             logic [7:0] sw_val = 8'h00);
      for (int i = 0; i < p; i++) begin
         rx_hs = (i < hs_hi);
         rx_vs = (vs_off >= 0) && (i >= vs_off) && (i < vs_off + 10);
         if (i == sw_off) sw = sw_val;
         tick();
      end
   endtask

   initial begin
      int c;
      int e;
      rst   = 1'b1;
      rx_hs = 1'b0;
      rx_vs = 1'b0;
      sw    = 8'h03;
      exp_reset(2);
      repeat (3) tick();
      rst = 1'b0;
      // Align the first hs so its measured width is a full 1650-cycle line.
      repeat (1648) tick();

      // Lock acquisition at 1650 cycles/line.
      for (int n = 0; n < 4; n++) begin
         c = cyc;
         if (n == 0) begin
            exp_at(c + 2, S_LINE_LEN, 1649);
            exp_at(c + 2, S_ADDR, 0);
            exp_at(c + 3, S_ADDR, 1);
         end
         if (n == 3) begin
            exp_at(c + 1, S_LOCKED, 0);
            exp_at(c + 2, S_LOCKED, 1);
            exp_at(c + 2, S_BYPASS, 1);
         end
         drive_line(1650, 40, -1);
      end
      c = cyc;
      exp_at(c + 101, S_BYPASS, 1);
      exp_at(c + 102, S_BYPASS, 0);
      exp_at(c + 102, S_KERN_SEL, 8'h03);
      exp_at(c + 102, S_FRAME_LINES, 5);
      drive_line(1650, 40, 100);

      // Mid-frame switch change is held off until the next vs.
      c = cyc;
      exp_at(c + 300, S_KERN_SEL, 8'h03);
      drive_line(1650, 40, -1, 200, 8'h05);
      c = cyc;
      exp_at(c + 101, S_KERN_SEL, 8'h03);
      exp_at(c + 102, S_KERN_SEL, 8'h05);
      exp_at(c + 102, S_FRAME_LINES, 2);
      drive_line(1650, 40, 100);

      // One long line breaks lock; four equal lines re-acquire it.
      drive_line(1651, 40, -1);
      for (int n = 8; n < 12; n++) begin
         c = cyc;
         if (n == 8) begin
            exp_at(c + 1, S_LOCKED, 1);
            exp_at(c + 2, S_LOCKED, 0);
            exp_at(c + 2, S_BYPASS, 1);
            exp_at(c + 2, S_LINE_LEN, 1650);
         end
         drive_line(1650, 40, -1);
      end
      c = cyc;
      exp_at(c + 1, S_LOCKED, 0);
      exp_at(c + 2, S_LOCKED, 1);
      exp_at(c + 2, S_BYPASS, 1);
      exp_at(c + 101, S_BYPASS, 1);
      exp_at(c + 102, S_BYPASS, 0);
      exp_at(c + 102, S_KERN_SEL, 8'h05);
      drive_line(1650, 40, 100);

      // Period shrinks to 800 while addr is past the new line length.
      c = cyc;
      exp_at(c + 2, S_ADDR, 0);
      exp_at(c + 2, S_LINE_LEN, 1649);
      drive_line(800, 40, -1);
      c = cyc;
      exp_at(c + 2, S_ADDR, 800);
      exp_at(c + 3, S_ADDR, 0);
      exp_at(c + 2, S_LINE_LEN, 799);
      exp_at(c + 2, S_LOCKED, 0);
      exp_at(c + 2, S_BYPASS, 1);
      exp_at(c + 802, S_ADDR, 799);
      exp_at(c + 803, S_ADDR, 0);
      drive_line(800, 40, -1);

      // Frame counting with short lines; first vs arrives while unlocked.
      c = cyc;
      exp_at(c + 32, S_FRAME_LINES, 3);
      exp_at(c + 32, S_BYPASS, 1);
      exp_at(c + 32, S_KERN_SEL, 8'h05);
      drive_line(40, 20, 30);
      drive_line(40, 20, -1, 5, 8'h0A);
      for (int n = 17; n < 765; n++) drive_line(40, 20, -1);
      c = cyc;
      exp_at(c + 32, S_FRAME_LINES, 750);
      exp_at(c + 31, S_BYPASS, 1);
      exp_at(c + 32, S_BYPASS, 0);
      exp_at(c + 31, S_KERN_SEL, 8'h05);
      exp_at(c + 32, S_KERN_SEL, 8'h0A);
      drive_line(40, 20, 30);
      drive_line(40, 20, -1);
      c = cyc;
      exp_at(c + 2, S_FRAME_LINES, 1);
      drive_line(40, 20, 0);
      c = cyc;
      e = c + 2;
      exp_at(c + 32, S_FRAME_LINES, 2);
      exp_at(e + 4095, S_LOCKED, 1);
      exp_at(e + 4096, S_LOCKED, 0);
      exp_at(e + 4096, S_BYPASS, 1);
      drive_line(40, 20, 30);

      // hs lost: width counter saturates and lock times out.
      repeat (5000) tick();
      c = cyc;
      exp_at(c + 2, S_LINE_LEN, 4095);
      drive_line(100, 20, -1);

      c = cyc;
      rst = 1'b1;
      exp_reset(c + 1);
      tick();
      rst = 1'b0;
      repeat (5) tick();

      foreach (sb[i]) begin
         checks++;
         failures++;
         $display("FAIL missed_%s cyc=%0d actual=none expected=%0d", sb[i].sig.name(), sb[i].cyc,
                  sb[i].val);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
